// File: rtl/audio_fir_decim.sv
// Decimating audio FIR: pops DECIM samples, runs NUM_TAPS serial multiply-accumulates, pushes one result.
// Define AUDIO_FIR_SATURATE_EN to clamp the presented output to the signed 16-bit range.
module audio_fir_decim #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_TAPS  = 32,
  parameter int DECIM     = 8,
  parameter logic signed [DATA_SIZE-1:0] COEFFS [NUM_TAPS] = '{
    1, 2, 3, 2, -2, -8, -14, -16, -8, 12, 42, 78, 112, 136, 148, 152,
    152, 148, 136, 112, 78, 42, 12, -8, -16, -14, -8, -2, 2, 3, 2, 1
  }
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 x_rd_en,
  input  logic                 x_empty,
  input  logic [DATA_SIZE-1:0] x_din,
  output logic [DATA_SIZE-1:0] y_dout,
  output logic                 y_wr_en,
  input  logic                 y_full
);

  // state | meaning
  // LOAD  | pop samples into the history until DECIM have arrived
  // MAC   | one tap per cycle, tap_idx 0..NUM_TAPS-1
  // WRITE | present y_dout, push once the downstream FIFO has room

  localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [TW-1:0] LAST_TAP  = TW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] LAST_LOAD = CW'(DECIM - 1);
  localparam logic signed [DATA_SIZE-1:0] SAT_MAX = 32767;
  localparam logic signed [DATA_SIZE-1:0] SAT_MIN = -32768;

  typedef enum logic [1:0] {LOAD, MAC, WRITE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_SIZE-1:0] taps [NUM_TAPS];
  logic        [CW-1:0]        load_cnt;
  logic        [TW-1:0]        tap_idx;
  logic signed [DATA_SIZE-1:0] acc;
  logic signed [DATA_SIZE-1:0] acc_sum;
  logic signed [DATA_SIZE-1:0] prod_lo;
  logic signed [DATA_SIZE-1:0] prod_mag;
  logic signed [DATA_SIZE-1:0] term;
  logic signed [DATA_SIZE-1:0] y_val;
  logic                        accept;
  logic                        last_load;
  logic                        last_tap;

  // Only the low half of the full product is consumed, so the truncated multiply gives identical bits.
  always_comb begin
    prod_lo  = COEFFS[tap_idx] * taps[tap_idx];
    prod_mag = prod_lo[DATA_SIZE-1] ? -prod_lo : prod_lo;
    term     = prod_lo[DATA_SIZE-1] ? -(prod_mag >>> 10) : (prod_mag >>> 10);
    acc_sum  = acc + term;
`ifdef AUDIO_FIR_SATURATE_EN
    if (acc_sum > SAT_MAX)
      y_val = SAT_MAX;
    else if (acc_sum < SAT_MIN)
      y_val = SAT_MIN;
    else
      y_val = acc_sum;
`else
    y_val = acc_sum;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  always_comb begin
    accept    = (state == LOAD) && !x_empty && !reset;
    x_rd_en   = accept;
    y_wr_en   = (state == WRITE) && !y_full && !reset;
    last_load = (load_cnt == LAST_LOAD);
    last_tap  = (tap_idx == LAST_TAP);
    state_nxt = state;
    case (state)
      LOAD:    if (accept && last_load) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = WRITE;
      WRITE:   if (!y_full) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_cnt <= '0;
      tap_idx  <= '0;
      acc      <= '0;
      y_dout   <= '0;
      for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            taps[0] <= x_din;
            for (int i = 1; i < NUM_TAPS; i++) taps[i] <= taps[i-1];
            load_cnt <= last_load ? '0 : load_cnt + CW'(1);
            if (last_load) begin
              acc     <= '0;
              tap_idx <= '0;
            end
          end
        end
        MAC: begin
          acc     <= acc_sum;
          tap_idx <= last_tap ? '0 : tap_idx + TW'(1);
          if (last_tap) y_dout <= y_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fir_decim.sv
// Bench for audio_fir_decim: three instances (ramp, flat-4, flat-1024 coefficients) share one stimulus
// and are checked against an arithmetic FIR model of the sample history.
module tb_audio_fir_decim;

  localparam int NT  = 32;
  localparam int DEC = 8;

  typedef logic signed [31:0] coef_t [NT];

  localparam coef_t RAMP = '{
    1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
    17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32
  };
  localparam coef_t FLAT4  = '{default: 4};
  localparam coef_t FLAT1K = '{default: 1024};

`ifdef AUDIO_FIR_SATURATE_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = 64000000;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        x_empty;
  logic        y_full;
  logic [31:0] x_din;
  logic        rd_r, wr_r, rd_f, wr_f, rd_k, wr_k;
  logic [31:0] y_r, y_f, y_k;
  logic [31:0] got_r, got_f, got_k;

  int errors = 0;
  int checks = 0;
  int hist [NT];
  int imp_exp [4] = '{1, 9, 17, 25};

  always #5 clock = ~clock;

  audio_fir_decim #(.DATA_SIZE(32), .NUM_TAPS(NT), .DECIM(DEC), .COEFFS(RAMP)) u_ramp (
    .clock(clock), .reset(reset), .x_rd_en(rd_r), .x_empty(x_empty), .x_din(x_din),
    .y_dout(y_r), .y_wr_en(wr_r), .y_full(y_full)
  );
  audio_fir_decim #(.DATA_SIZE(32), .NUM_TAPS(NT), .DECIM(DEC), .COEFFS(FLAT4)) u_flat (
    .clock(clock), .reset(reset), .x_rd_en(rd_f), .x_empty(x_empty), .x_din(x_din),
    .y_dout(y_f), .y_wr_en(wr_f), .y_full(y_full)
  );
  audio_fir_decim #(.DATA_SIZE(32), .NUM_TAPS(NT), .DECIM(DEC), .COEFFS(FLAT1K)) u_big (
    .clock(clock), .reset(reset), .x_rd_en(rd_k), .x_empty(x_empty), .x_din(x_din),
    .y_dout(y_k), .y_wr_en(wr_k), .y_full(y_full)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Expected output: dot product of coefficients and history, each product truncated to 32 bits
  // and divided by 1024 rounding toward zero, summed with 32-bit wrap.
  function automatic int model_out(input coef_t c);
    int     acc;
    int     lo;
    longint p;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      p   = longint'(c[k]) * longint'(hist[k]);
      lo  = int'(p);
      acc = acc + lo / 1024;
    end
`ifdef AUDIO_FIR_SATURATE_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 200000)) - 100000;
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < NT; i++) hist[i] = 0;
  endtask

  task automatic push_hist(input int v);
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic feed(input int v);
    bit done;
    done    = 1'b0;
    x_din   = v;
    x_empty = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clock);
      if (rd_r) begin
        done = 1'b1;
        check("pop_flat", rd_f, 1);
        check("pop_big", rd_k, 1);
      end
      @(posedge clock); #1;
    end
    check("pop_seen", done, 1);
    if (done) push_hist(v);
    x_empty = 1'b1;
  endtask

  task automatic stall(input int cycles);
    x_empty = 1'b1;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clock);
      check("no_pop_starved", rd_r, 0);
      @(posedge clock); #1;
    end
  endtask

  // Called at the start of the cycle after the batch's last pop; input stays non-empty to
  // prove no pop happens while busy. With hold>0 the downstream is full for hold WRITE cycles.
  task automatic wait_output(input int hold);
    bit          seen;
    logic [31:0] held;
    int          lat;
    seen    = 1'b0;
    held    = '0;
    lat     = NT + 1 + hold;
    x_empty = 1'b0;
    x_din   = $urandom;
    for (int n = 1; n <= 200 && !seen; n++) begin
      y_full = (hold > 0) && (n < lat);
      @(negedge clock);
      if (wr_r) begin
        seen  = 1'b1;
        got_r = y_r;
        got_f = y_f;
        got_k = y_k;
        check("latency", n, lat);
        check("no_pop_in_write", rd_r, 0);
        check("push_flat", wr_f, 1);
        check("push_big", wr_k, 1);
        check("y_ramp", y_r, model_out(RAMP));
        check("y_flat4", y_f, model_out(FLAT4));
        check("y_flat1k", y_k, model_out(FLAT1K));
      end else begin
        check("no_pop_busy", rd_r, 0);
        if (hold > 0 && n == NT + 1) held = y_r;
        if (hold > 0 && n > NT + 1) check("dout_stable_full", y_r, held);
      end
      @(posedge clock); #1;
    end
    check("push_seen", seen, 1);
    x_empty = 1'b1;
    y_full  = 1'b0;
    @(negedge clock);
    check("single_push", wr_r, 0);
    @(posedge clock); #1;
  endtask

  task automatic run_impulse();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < DEC; i++) feed((b == 0 && i == DEC - 1) ? 1024 : 0);
      wait_output(0);
      check("impulse", got_r, imp_exp[b]);
    end
  endtask

  initial begin
    reset   = 1'b1;
    x_empty = 1'b0;
    y_full  = 1'b0;
    x_din   = 32'd77;
    clear_hist();

    // Reset: strobes held low even with data available.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_rd", rd_r, 0);
      check("reset_wr", wr_r, 0);
    end
    @(posedge clock); #1;
    reset   = 1'b0;
    x_empty = 1'b1;
    @(negedge clock);
    check("reset_dout", y_r, 0);
    check("reset_dout_big", y_k, 0);
    @(posedge clock); #1;

    // Impulse through ramp coefficients.
    run_impulse();

    // DC input: steady-state once the full history holds the constant.
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < DEC; i++) feed(1024);
      wait_output(0);
      if (b >= 3) check("dc_flat4", got_f, 128);
    end

    // Large constant input: saturation or wrap-free full value.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < DEC; i++) feed(2000000);
      wait_output(0);
    end
    check("sat_flat1k", got_k, SAT_EXP);

    // Backpressure for 20 cycles in WRITE.
    for (int i = 0; i < DEC; i++) feed(rnd());
    wait_output(20);

    // Input starvation after the third sample.
    for (int i = 0; i < DEC; i++) begin
      feed(rnd());
      if (i == 2) stall(5);
    end
    wait_output(0);

    // Reset at tap 10 of a MAC pass: no push may follow and history restarts from zero.
    for (int i = 0; i < DEC; i++) feed(rnd());
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_hist();
    for (int t = 0; t < 60; t++) begin
      @(negedge clock);
      check("no_push_after_reset", wr_r, 0);
      if (t == 0) check("dout_after_reset", y_r, 0);
      @(posedge clock); #1;
    end
    run_impulse();

    // Randomized batches with random starvation gaps and backpressure.
    for (int b = 0; b < 12; b++) begin
      int gp, gl;
      gp = int'($urandom_range(0, DEC - 1));
      gl = int'($urandom_range(0, 3));
      for (int i = 0; i < DEC; i++) begin
        feed(rnd());
        if (i == gp && gl > 0 && i != DEC - 1) stall(gl);
      end
      wait_output(int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_fir_decim.md
AUDIO_FIR_DECIM -- requirements
Module: audio_fir_decim

Interface
REQ-001 Parameter DATA_SIZE, default 32: sample, coefficient and output width.
REQ-002 Parameter NUM_TAPS, default 32: number of FIR taps.
REQ-003 Parameter DECIM, default 8: decimation factor, 1 <= DECIM <= NUM_TAPS.
REQ-004 Parameter COEFFS, default team audio low-pass table: NUM_TAPS signed DATA_SIZE-bit coefficients, Q10 fixed point.
REQ-005 The block SHALL have one clock and synchronous, active-high reset, named as follows:
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- x_rd_en  out  1  pop strobe to upstream demod-output FIFO
- x_empty  in  1  upstream FIFO empty
- x_din  in  DATA_SIZE  signed Q10 sample at FIFO head, valid while x_empty=0
- y_dout  out  DATA_SIZE  signed filtered, decimated sample
- y_wr_en  out  1  push strobe to downstream FIFO
- y_full  in  1  downstream FIFO full

Function
REQ-006 The block SHALL hold a NUM_TAPS-entry sample shift register; entry 0 is newest; each accepted sample shifts all entries up one and drops entry NUM_TAPS-1.
REQ-007 States SHALL be LOAD, MAC, WRITE; reset state LOAD.
REQ-008 LOAD: when x_empty=0, assert x_rd_en for exactly that cycle, shift x_din into entry 0, increment a load counter; when x_empty=1, x_rd_en=0 and nothing changes.
REQ-009 LOAD SHALL go to MAC in the cycle after the DECIM-th sample of the current batch is accepted; load counter clears on that transition.
REQ-010 MAC SHALL take exactly NUM_TAPS cycles, one tap k per cycle, k = 0..NUM_TAPS-1; accumulator clears on MAC entry.
REQ-011 Per tap: product = signed(COEFFS[k]) * signed(entry k), full 2*DATA_SIZE bits; the low DATA_SIZE bits SHALL be DEQUANTIZEd and added into a DATA_SIZE-bit signed accumulator, two's-complement wrap on overflow.
REQ-012 DEQUANTIZE(v) SHALL be symmetric about zero: v>=0 -> v>>>10; v<0 -> -((-v)>>>10).
REQ-013 After tap NUM_TAPS-1 the block SHALL enter WRITE with y_dout holding the accumulator (subject to REQ-019).
REQ-014 WRITE: when y_full=0, assert y_wr_en for exactly one cycle and return to LOAD; when y_full=1, hold WRITE, y_wr_en=0, y_dout stable.
REQ-015 x_rd_en SHALL never be asserted outside LOAD; y_wr_en SHALL never be asserted outside WRITE; both never asserted in the same cycle.
REQ-016 One output SHALL be produced per DECIM accepted inputs; minimum input-to-output latency after the DECIM-th pop is NUM_TAPS+1 cycles.
REQ-017 Shift register contents SHALL persist across batches (no clearing between outputs).

Reset
REQ-018 With reset=1 at a rising edge: state=LOAD, load counter=0, tap index=0, accumulator=0, all shift entries=0, y_dout=0; x_rd_en=0, y_wr_en=0 during reset; reset mid-MAC or mid-WRITE SHALL discard the pending output.

Configuration
REQ-019 Macro AUDIO_FIR_SATURATE_EN: when defined, the value presented on y_dout SHALL be the accumulator clamped to [-32768, 32767]; when undefined, y_dout SHALL be the accumulator unmodified.

Verification
REQ-020 Impulse: COEFFS[k]=k+1, DECIM=8; input 1024 then 31 zeros, no backpressure -> outputs 1, 9, 17, 25 (COEFFS[0], [8], [16], [24]).
REQ-021 DC: COEFFS all 4, input constant 1024 -> 4th and later outputs = 128 (32 taps x 4).
REQ-022 Backpressure: y_full=1 for 20 cycles on entering WRITE -> y_wr_en stays 0, y_dout constant, x_rd_en 0; single push one cycle after y_full falls.
REQ-023 Input starvation: x_empty=1 for 5 cycles after 3rd sample of a batch -> no pops, state stays LOAD, output value identical to unstalled run.
REQ-024 Reset mid-MAC at tap 10 -> no y_wr_en follows; next batch of impulse stimulus reproduces REQ-020 outputs from zeroed history.
REQ-025 Saturation: COEFFS all 1024, input constant 2000000 -> with AUDIO_FIR_SATURATE_EN y_dout=32767; without it y_dout=64000000.
